sha_add_arbiter: RTL and testbench

- Shares one WIDTH-bit Kogge-Stone adder instance, KSA with size=WIDTH, between NREQ requesters inside the SHA-256 round datapath. Typical requesters are the T1, T2, message-schedule and digest-update paths.
- Arbitration is round-robin, with an optional lock so one requester can chain several dependent additions, e.g. the four adds of T1, without interruption.
- Results are registered, returned with a requester ID, and support output backpressure.

---
 rtl/sha_add_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sha_add_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sha_add_arbiter (with ksa)
// Brief    : Round-robin arbiter with ownership lock that time-shares a single
//            Kogge-Stone adder between SHA-256 datapath requesters.
// Revision : 1.0 - initial release
// ============================================================================

module ksa #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            ci,
    output logic [SIZE-1:0] sum,
    output logic            co
);
    localparam int c_levels = (SIZE > 1) ? $clog2(SIZE) : 0;

    logic [SIZE-1:0] w_g;
    logic [SIZE-1:0] w_p;
    logic [SIZE-1:0] w_gg;
    logic [SIZE-1:0] w_pp;
    logic [SIZE-1:0] w_gn;
    logic [SIZE-1:0] w_pn;
    logic [SIZE:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Prefix tree: level l combines each bit with the group 2^l positions below.
    always_comb begin
        w_gg = w_g;
        w_pp = w_p;
        w_gn = w_g;
        w_pn = w_p;
        for (int l = 0; l < c_levels; l++) begin
            w_gn = w_gg;
            w_pn = w_pp;
            for (int i = (1 << l); i < SIZE; i++) begin
                w_gn[i] = w_gg[i] | (w_pp[i] & w_gg[i-(1<<l)]);
                w_pn[i] = w_pp[i] & w_pp[i-(1<<l)];
            end
            w_gg = w_gn;
            w_pp = w_pn;
        end
    end

    // Carry-in enters every group term through the group propagate.
    assign w_c = {w_gg | (w_pp & {SIZE{ci}}), ci};
    assign sum = w_p ^ w_c[SIZE-1:0];
    assign co  = w_c[SIZE];

endmodule

module sha_add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] a_flat,
    input  logic [NREQ*WIDTH-1:0] b_flat,
    input  logic [NREQ-1:0]       ci,
    output logic [NREQ-1:0]       gnt,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_co,
    output logic                  locked
);
    localparam int c_last = NREQ - 1;

    logic             r_res_valid;
    logic [IDW-1:0]   r_res_id;
    logic [WIDTH-1:0] r_res_sum;
    logic             r_res_co;
    logic             r_locked;
    logic [IDW-1:0]   r_lock_owner;
    logic [IDW-1:0]   r_ptr;

    logic             w_can_accept;
    logic             w_hit;
    logic             w_fire;
    logic [IDW-1:0]   w_idx;
    int               w_pos;
    logic [NREQ-1:0]  w_gnt;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_ci;
    logic [WIDTH-1:0] w_sum;
    logic             w_co;

    assign w_can_accept = ~r_res_valid | res_ready;

    // Scan from the farthest offset down so the nearest requester to the
    // pointer is the last assignment and therefore wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_pos = 0;
        if (r_locked) begin
            w_hit = req[r_lock_owner];
            w_idx = r_lock_owner;
        end else begin
            for (int off = NREQ - 1; off >= 0; off--) begin
                w_pos = (int'(r_ptr) + off) % NREQ;
                if (req[w_pos]) begin
                    w_hit = 1'b1;
                    w_idx = IDW'(w_pos);
                end
            end
        end
    end

    assign w_fire = rst_n & w_can_accept & w_hit;

    always_comb begin
        w_gnt = '0;
        if (w_fire) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    assign gnt = w_gnt;

    assign w_a  = a_flat[w_idx*WIDTH +: WIDTH];
    assign w_b  = b_flat[w_idx*WIDTH +: WIDTH];
    assign w_ci = ci[w_idx];

    ksa #(
        .SIZE (WIDTH)
    ) u_ksa (
        .a   (w_a),
        .b   (w_b),
        .ci  (w_ci),
        .sum (w_sum),
        .co  (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid  <= 1'b0;
            r_res_id     <= '0;
            r_res_sum    <= '0;
            r_res_co     <= 1'b0;
            r_locked     <= 1'b0;
            r_lock_owner <= '0;
            r_ptr        <= '0;
        end else if (w_fire) begin
            r_res_valid <= 1'b1;
            r_res_id    <= w_idx;
            r_res_sum   <= w_sum;
            r_res_co    <= w_co;
            r_ptr       <= (w_idx == IDW'(c_last)) ? '0 : w_idx + IDW'(1);
            r_locked    <= lock[w_idx];
            if (lock[w_idx]) begin
                r_lock_owner <= w_idx;
            end
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_sum   = r_res_sum;
    assign res_co    = r_res_co;
    assign locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_sha_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_add_arbiter
// Brief    : Scoreboard bench: stimulus pushes expected results, monitor pops.
// Revision : 1.0 - initial release
// ============================================================================

module tb_sha_add_arbiter;
    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   lock;
    logic [127:0] a_flat;
    logic [127:0] b_flat;
    logic [3:0]   ci;
    logic [3:0]   gnt;
    logic         res_valid;
    logic         res_ready;
    logic [1:0]   res_id;
    logic [31:0]  res_sum;
    logic         res_co;
    logic         locked;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        co;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    sha_add_arbiter #(.NREQ(4), .WIDTH(32), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .ci        (ci),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_co    (res_co),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [31:0] x, input logic [31:0] y, input logic c);
        a_flat[k*32 +: 32] = x;
        b_flat[k*32 +: 32] = y;
        ci[k]              = c;
    endtask

    function automatic logic [32:0] model(input int k);
        return {1'b0, a_flat[k*32 +: 32]} + {1'b0, b_flat[k*32 +: 32]} + 33'(ci[k]);
    endfunction

    task automatic push_exp(input int k);
        logic [32:0] s;
        s = model(k);
        q.push_back('{id: 2'(k), sum: s[31:0], co: s[32]});
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] lk, input logic rdy,
                        input logic [3:0] eg, input string nm);
        @(negedge clk);
        req       = r;
        lock      = lk;
        res_ready = rdy;
        #1;
        check(nm, 64'(gnt), 64'(eg));
        for (int k = 0; k < 4; k++) begin
            if (eg[k]) push_exp(k);
        end
    endtask

    // Monitor: consumes one expected entry per accepted result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && res_valid && res_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got id=%0d sum=%0h none expected", res_id, res_sum);
                end else begin
                    e = q.pop_front();
                    check("mon_id",  64'(res_id),  64'(e.id));
                    check("mon_sum", 64'(res_sum), 64'(e.sum));
                    check("mon_co",  64'(res_co),  64'(e.co));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] s0;
        logic [32:0] s1;
        rst_n = 1'b0; req = 4'b1111; lock = 4'b0; res_ready = 1'b1;
        a_flat = '0; b_flat = '0; ci = '0;
        #12;
        check("rst_gnt",    64'(gnt),       64'h0);
        check("rst_valid",  64'(res_valid), 64'h0);
        check("rst_id",     64'(res_id),    64'h0);
        check("rst_sum",    64'(res_sum),   64'h0);
        check("rst_co",     64'(res_co),    64'h0);
        check("rst_locked", 64'(locked),    64'h0);
        @(negedge clk);
        req = 4'b0;
        rst_n = 1'b1;

        // Single add
        set_op(0, 32'h6A09E667, 32'hBB67AE85, 1'b0);
        step(4'b0001, 4'b0, 1'b1, 4'b0001, "t1_gnt");
        step(4'b0000, 4'b0, 1'b1, 4'b0000, "t1_idle");
        check("t1_valid", 64'(res_valid), 64'h1);
        check("t1_id",    64'(res_id),    64'h0);
        check("t1_sum",   64'(res_sum),   64'h257194EC);
        check("t1_co",    64'(res_co),    64'h1);

        // Wrap-around with carry-in, then MSB overflow
        set_op(1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        step(4'b0010, 4'b0, 1'b1, 4'b0010, "wrap1_gnt");
        set_op(2, 32'h80000000, 32'h80000000, 1'b0);
        step(4'b0100, 4'b0, 1'b1, 4'b0100, "wrap2_gnt");
        check("wrap1_sum", 64'(res_sum), 64'h0);
        check("wrap1_co",  64'(res_co),  64'h1);
        step(4'b0000, 4'b0, 1'b1, 4'b0000, "wrap_idle");
        check("wrap2_id",  64'(res_id),  64'h2);
        check("wrap2_sum", 64'(res_sum), 64'h0);
        check("wrap2_co",  64'(res_co),  64'h1);

        // Round-robin with every requester held, pointer starting at 3
        for (int k = 0; k < 4; k++) begin
            set_op(k, 32'h01234567 << k, 32'hFEDCBA98 - 32'(k), 1'(k));
        end
        step(4'b1111, 4'b0, 1'b1, 4'b1000, "rr0");
        step(4'b1111, 4'b0, 1'b1, 4'b0001, "rr1");
        step(4'b1111, 4'b0, 1'b1, 4'b0010, "rr2");
        step(4'b1111, 4'b0, 1'b1, 4'b0100, "rr3");
        step(4'b1111, 4'b0, 1'b1, 4'b1000, "rr4");
        step(4'b0000, 4'b0, 1'b1, 4'b0000, "rr_idle");

        // Lock chain on requester 2
        step(4'b0100, 4'b0100, 1'b1, 4'b0100, "lk0");
        check("lk0_locked", 64'(locked), 64'h0);
        step(4'b1111, 4'b0100, 1'b1, 4'b0100, "lk1");
        check("lk1_locked", 64'(locked), 64'h1);
        step(4'b1111, 4'b0100, 1'b1, 4'b0100, "lk2");
        check("lk2_locked", 64'(locked), 64'h1);
        step(4'b1111, 4'b0000, 1'b1, 4'b0100, "lk3");
        check("lk3_locked", 64'(locked), 64'h1);
        step(4'b1111, 4'b0000, 1'b1, 4'b1000, "lk_after");
        check("lk_after_locked", 64'(locked), 64'h0);

        // Owner idle still blocks everyone else
        step(4'b0001, 4'b0001, 1'b1, 4'b0001, "own_lock");
        step(4'b1110, 4'b0000, 1'b1, 4'b0000, "own_idle_block");
        check("own_idle_locked", 64'(locked), 64'h1);
        step(4'b1111, 4'b0000, 1'b1, 4'b0001, "own_release");
        step(4'b1110, 4'b0000, 1'b1, 4'b0010, "own_after");
        check("own_after_locked", 64'(locked), 64'h0);
        step(4'b0000, 4'b0, 1'b1, 4'b0000, "own_idle");

        // Backpressure: three stalled cycles, then resume
        s0 = model(0);
        s1 = model(1);
        step(4'b0011, 4'b0, 1'b1, 4'b0001, "bp_first");
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 4'b0, 1'b0, 4'b0000, "bp_stall_gnt");
            check("bp_stall_id",  64'(res_id),  64'h0);
            check("bp_stall_sum", 64'(res_sum), 64'(s0[31:0]));
        end
        step(4'b0011, 4'b0, 1'b1, 4'b0010, "bp_resume");
        step(4'b0000, 4'b0, 1'b1, 4'b0000, "bp_drain");
        step(4'b0000, 4'b0, 1'b1, 4'b0000, "bp_empty");
        check("bp_valid_clear", 64'(res_valid), 64'h0);
        check("bp_id_hold",     64'(res_id),    64'h1);
        check("bp_sum_hold",    64'(res_sum),   64'(s1[31:0]));

        // Asynchronous reset while a lock and a result are held
        step(4'b1000, 4'b1000, 1'b1, 4'b1000, "rl_gnt");
        @(negedge clk);
        res_ready = 1'b0;
        req = 4'b1111;
        lock = 4'b0;
        #1;
        check("rl_pre_locked", 64'(locked),    64'h1);
        check("rl_pre_valid",  64'(res_valid), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rl_valid",  64'(res_valid), 64'h0);
        check("rl_locked", 64'(locked),    64'h0);
        check("rl_gnt",    64'(gnt),       64'h0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        check("rl_first_gnt", 64'(gnt), 64'b0001);
        push_exp(0);
        step(4'b0000, 4'b0, 1'b1, 4'b0000, "end_idle0");
        step(4'b0000, 4'b0, 1'b1, 4'b0000, "end_idle1");
        check("queue_empty", 64'(q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
